// File: rtl/bfm_apb_slave_mem.sv
// APB3 completer model with a word memory, programmable wait states and error responses.
// Latency: setup cycle T0, completion (PREADY=1 for one cycle) at T(1+WAIT_CFG).
// Backpressure: PREADY is held low for WAIT_CFG cycles after setup; PSEL=0 mid-transfer aborts it.
//
// Ports:
//   PCLK, PRESETN          clock, synchronous active-low reset
//   PSEL/PENABLE/PWRITE    APB control from the requester
//   PADDR/PWDATA           byte address and write data
//   PRDATA/PREADY/PSLVERR  registered completion response
//   WAIT_CFG               wait states for the transfer, sampled in the setup cycle
//   XFER_CNT               completed-transfer count (errored ones included), wraps at 16 bits
//   PROT_ERR               sticky protocol-violation flag
//
// Optional feature macro: BFM_APB_SLAVE_PROTCHECK_EN
//   defined   -> protocol checker built, PROT_ERR sticky until reset, violations are printed
//   undefined -> PROT_ERR tied low, setup-value capture registers are not built
module bfm_apb_slave_mem #(
    parameter int AWIDTH = 10,
    parameter int TPD    = 1
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic [3:0]  WAIT_CFG,
    output logic [15:0] XFER_CNT,
    output logic        PROT_ERR
);

    localparam int DEPTH = 1 << (AWIDTH - 2);

    // Outputs change on the clock edge; TPD is only a parameter hook for the
    // bus model and has no effect on cycle behaviour. Reject nonsense values early.
    if (TPD < 0) begin : g_bad_tpd
        $error("bfm_apb_slave_mem: TPD must be non-negative");
    end
    if (AWIDTH < 3 || AWIDTH > 31) begin : g_bad_awidth
        $error("bfm_apb_slave_mem: AWIDTH must be in 3..31");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic [AWIDTH-3:0]   addr_q, addr_nxt;
    logic                write_q, write_nxt;
    logic                err_q, err_nxt;
    logic [31:0]         prdata_nxt;
    logic                pready_nxt;
    logic                pslverr_nxt;
    logic                mem_we;
    logic                cnt_inc;
    logic                addr_err;
    logic                setup;

    // Zero at elaboration; deliberately outside the reset domain.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    assign setup    = PSEL && !PENABLE;
    assign addr_err = (PADDR[1:0] != 2'b00) || (|PADDR[31:AWIDTH]);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        addr_nxt    = addr_q;
        write_nxt   = write_q;
        err_nxt     = err_q;
        prdata_nxt  = 32'h0;
        pready_nxt  = 1'b0;
        pslverr_nxt = 1'b0;
        mem_we      = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (setup) begin
                    addr_nxt  = PADDR[AWIDTH-1:2];
                    write_nxt = PWRITE;
                    err_nxt   = addr_err;
                    cnt_nxt   = WAIT_CFG;
                    if (WAIT_CFG == 4'd0) begin
                        pready_nxt  = 1'b1;
                        pslverr_nxt = addr_err;
                        prdata_nxt  = (!addr_err && !PWRITE) ? mem[PADDR[AWIDTH-1:2]] : 32'h0;
                        state_nxt   = ST_ACCESS;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    // Counter at 1 means this is the last wait cycle: enter completion.
                    if (cnt == 4'd1) begin
                        pready_nxt  = 1'b1;
                        pslverr_nxt = err_q;
                        prdata_nxt  = (!err_q && !write_q) ? mem[addr_q] : 32'h0;
                        state_nxt   = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                // Completion and abort both return to IDLE with outputs cleared;
                // only a completion (PSEL still high) writes and counts.
                state_nxt = ST_IDLE;
                cnt_nxt   = 4'd0;
                if (PSEL) begin
                    mem_we  = write_q && !err_q;
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            PRDATA   <= 32'h0;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            XFER_CNT <= 16'h0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            addr_q  <= addr_nxt;
            write_q <= write_nxt;
            err_q   <= err_nxt;
            PRDATA  <= prdata_nxt;
            PREADY  <= pready_nxt;
            PSLVERR <= pslverr_nxt;
            if (cnt_inc) begin
                XFER_CNT <= XFER_CNT + 16'd1;
            end
        end
    end

    // Reset in the completion cycle discards the pending write.
    always_ff @(posedge PCLK) begin
        if (PRESETN && mem_we) begin
            mem[addr_q] <= PWDATA;
        end
    end

`ifdef BFM_APB_SLAVE_PROTCHECK_EN
    logic [31:0] paddr_s;
    logic [31:0] pwdata_s;
    logic        prot_err_q;
    logic        in_xfer;
    logic        viol_nosetup;
    logic        viol_drop;
    logic        viol_change;

    assign in_xfer      = (state == ST_WAIT) || (state == ST_ACCESS);
    assign viol_nosetup = (state == ST_IDLE) && PSEL && PENABLE;
    assign viol_drop    = in_xfer && !PSEL;
    assign viol_change  = in_xfer && PSEL &&
                          ((PADDR != paddr_s) || (PWRITE != write_q) ||
                           (write_q && (PWDATA != pwdata_s)));

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            paddr_s    <= 32'h0;
            pwdata_s   <= 32'h0;
            prot_err_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && setup) begin
                paddr_s  <= PADDR;
                pwdata_s <= PWDATA;
            end
            if (viol_nosetup || viol_drop || viol_change) begin
                prot_err_q <= 1'b1;
            end
            if (viol_nosetup) $display("[%0t] bfm_apb_slave_mem: PENABLE without setup cycle", $time);
            if (viol_drop)    $display("[%0t] bfm_apb_slave_mem: PSEL dropped mid-transfer", $time);
            if (viol_change)  $display("[%0t] bfm_apb_slave_mem: PADDR/PWRITE/PWDATA changed mid-transfer", $time);
        end
    end

    assign PROT_ERR = prot_err_q;
`else
    assign PROT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_bfm_apb_slave_mem.sv
// Directed bench for bfm_apb_slave_mem: zero-wait and wait-state transfers,
// error responses, abort, protocol flag, mid-transfer reset and back-to-back writes.
module tb_bfm_apb_slave_mem;

`ifdef BFM_APB_SLAVE_PROTCHECK_EN
    localparam logic EXP_PROT = 1'b1;
`else
    localparam logic EXP_PROT = 1'b0;
`endif

    logic        PCLK;
    logic        PRESETN;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [3:0]  WAIT_CFG;
    logic [15:0] XFER_CNT;
    logic        PROT_ERR;

    int checks = 0;
    int errors = 0;

    bfm_apb_slave_mem #(.AWIDTH(10), .TPD(1)) dut (
        .PCLK     (PCLK),
        .PRESETN  (PRESETN),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .WAIT_CFG (WAIT_CFG),
        .XFER_CNT (XFER_CNT),
        .PROT_ERR (PROT_ERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_prdata"},  PRDATA,  32'h0);
        check({tag, "_pready"},  {31'h0, PREADY},  32'h0);
        check({tag, "_pslverr"}, {31'h0, PSLVERR}, 32'h0);
    endtask

    // One full transfer. WAIT_CFG is overwritten with cfg_after once the setup
    // cycle has been clocked, to show the in-flight transfer ignores it.
    // Leaves PSEL/PENABLE high so a following call is truly back-to-back.
    task automatic apb_xfer(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] waits,
                            input logic [3:0] cfg_after,
                            input logic [31:0] exp_rdata, input logic exp_err);
        WAIT_CFG = waits;
        PSEL     = 1'b1;
        PENABLE  = 1'b0;
        PWRITE   = wr;
        PADDR    = addr;
        PWDATA   = wdata;
        step();
        PENABLE  = 1'b1;
        WAIT_CFG = cfg_after;
        for (int i = 1; i <= int'(waits); i++) begin
            check({tag, "_wait_pready"}, {31'h0, PREADY}, 32'h0);
            step();
        end
        check({tag, "_pready"},  {31'h0, PREADY},  32'h1);
        check({tag, "_prdata"},  PRDATA,           exp_rdata);
        check({tag, "_pslverr"}, {31'h0, PSLVERR}, {31'h0, exp_err});
        step();
        check_idle_outputs({tag, "_after"});
    endtask

    task automatic bus_idle();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    initial begin
        PRESETN  = 1'b0;
        PSEL     = 1'b1;   // setup cycle coincident with reset must be ignored
        PENABLE  = 1'b0;
        PWRITE   = 1'b0;
        PADDR    = 32'h0;
        PWDATA   = 32'h0;
        WAIT_CFG = 4'd0;
        step();
        step();
        check_idle_outputs("reset");
        check("reset_xfer_cnt", {16'h0, XFER_CNT}, 32'h0);
        check("reset_prot_err", {31'h0, PROT_ERR}, 32'h0);
        PRESETN = 1'b1;
        bus_idle();
        step();
        check("post_reset_pready", {31'h0, PREADY}, 32'h0);

        // Zero-wait write then read.
        apb_xfer("zw_wr", 1'b1, 32'h10, 32'hDEADBEEF, 4'd0, 4'd0, 32'h0, 1'b0);
        apb_xfer("zw_rd", 1'b0, 32'h10, 32'h0,        4'd0, 4'd0, 32'hDEADBEEF, 1'b0);
        bus_idle();
        check("zw_xfer_cnt", {16'h0, XFER_CNT}, 32'd2);

        // Three wait states; WAIT_CFG dropped to 0 mid-transfer has no effect.
        apb_xfer("w3_rd", 1'b0, 32'h10, 32'h0, 4'd3, 4'd0, 32'hDEADBEEF, 1'b0);
        bus_idle();
        check("w3_xfer_cnt", {16'h0, XFER_CNT}, 32'd3);

        // Error responses: misaligned write, out-of-window read, word 0 untouched.
        apb_xfer("err_wr", 1'b1, 32'h2,   32'hFFFFFFFF, 4'd0, 4'd0, 32'h0, 1'b1);
        apb_xfer("err_rd", 1'b0, 32'h400, 32'h0,        4'd1, 4'd1, 32'h0, 1'b1);
        apb_xfer("err_chk", 1'b0, 32'h0,  32'h0,        4'd0, 4'd0, 32'h0, 1'b0);
        bus_idle();
        check("err_xfer_cnt", {16'h0, XFER_CNT}, 32'd6);

        // PADDR changed during wait phase; transfer still uses the setup address.
        WAIT_CFG = 4'd2;
        PSEL     = 1'b1;
        PENABLE  = 1'b0;
        PWRITE   = 1'b0;
        PADDR    = 32'h10;
        step();
        PENABLE = 1'b1;
        PADDR   = 32'h14;
        check("prot_t1_pready", {31'h0, PREADY}, 32'h0);
        step();
        check("prot_t2_flag", {31'h0, PROT_ERR}, {31'h0, EXP_PROT});
        check("prot_t2_pready", {31'h0, PREADY}, 32'h0);
        step();
        check("prot_t3_pready", {31'h0, PREADY}, 32'h1);
        check("prot_t3_prdata", PRDATA, 32'hDEADBEEF);
        step();
        bus_idle();
        step();
        check("prot_held", {31'h0, PROT_ERR}, {31'h0, EXP_PROT});
        check("prot_xfer_cnt", {16'h0, XFER_CNT}, 32'd7);

        // Abort: PSEL dropped in the wait phase of a write.
        WAIT_CFG = 4'd2;
        PSEL     = 1'b1;
        PENABLE  = 1'b0;
        PWRITE   = 1'b1;
        PADDR    = 32'h30;
        PWDATA   = 32'h5555;
        step();
        PENABLE = 1'b1;
        step();
        bus_idle();
        step();
        check_idle_outputs("abort");
        step();
        check("abort_pready_late", {31'h0, PREADY}, 32'h0);
        check("abort_xfer_cnt", {16'h0, XFER_CNT}, 32'd7);
        apb_xfer("abort_rd", 1'b0, 32'h30, 32'h0, 4'd0, 4'd0, 32'h0, 1'b0);
        bus_idle();
        check("abort_rd_cnt", {16'h0, XFER_CNT}, 32'd8);

        // Reset at T2 of a 5-wait write.
        WAIT_CFG = 4'd5;
        PSEL     = 1'b1;
        PENABLE  = 1'b0;
        PWRITE   = 1'b1;
        PADDR    = 32'h20;
        PWDATA   = 32'h1234;
        step();
        PENABLE = 1'b1;
        step();
        PRESETN = 1'b0;
        step();
        check_idle_outputs("mid_reset");
        check("mid_reset_xfer_cnt", {16'h0, XFER_CNT}, 32'h0);
        check("mid_reset_prot_err", {31'h0, PROT_ERR}, 32'h0);
        PRESETN = 1'b1;
        bus_idle();
        step();

        // Four back-to-back zero-wait writes.
        apb_xfer("b2b_0", 1'b1, 32'h40, 32'hA0A0A0A0, 4'd0, 4'd0, 32'h0, 1'b0);
        apb_xfer("b2b_1", 1'b1, 32'h44, 32'hB1B1B1B1, 4'd0, 4'd0, 32'h0, 1'b0);
        apb_xfer("b2b_2", 1'b1, 32'h48, 32'hC2C2C2C2, 4'd0, 4'd0, 32'h0, 1'b0);
        apb_xfer("b2b_3", 1'b1, 32'h4C, 32'hD3D3D3D3, 4'd0, 4'd0, 32'h0, 1'b0);
        bus_idle();
        check("b2b_xfer_cnt", {16'h0, XFER_CNT}, 32'd4);

        apb_xfer("reset_wr_lost", 1'b0, 32'h20, 32'h0, 4'd0, 4'd0, 32'h0, 1'b0);
        apb_xfer("b2b_rd_1", 1'b0, 32'h44, 32'h0, 4'd1, 4'd1, 32'hB1B1B1B1, 1'b0);
        apb_xfer("b2b_rd_3", 1'b0, 32'h4C, 32'h0, 4'd0, 4'd0, 32'hD3D3D3D3, 1'b0);
        bus_idle();
        check("final_xfer_cnt", {16'h0, XFER_CNT}, 32'd7);
        check("final_prot_err", {31'h0, PROT_ERR}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
